// File: rtl/regfile_sb_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_sb_if : bus bundle for the scoreboarded register file    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
interface regfile_sb_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              EnWri;
    logic [ADDR_W-1:0] WriAdd;
    logic [WIDTH-1:0]  DataI;
    logic [ADDR_W-1:0] ReadA;
    logic [ADDR_W-1:0] ReadB;
    logic [WIDTH-1:0]  DataA;
    logic [WIDTH-1:0]  DataB;
    logic              BusyA;
    logic              BusyB;
    logic              EnRes;
    logic [ADDR_W-1:0] ResAdd;
    logic              Flush;
    logic              AnyBusy;

    modport master (
        output EnWri, WriAdd, DataI, ReadA, ReadB, EnRes, ResAdd, Flush,
        input  DataA, DataB, BusyA, BusyB, AnyBusy
    );

    modport slave (
        input  EnWri, WriAdd, DataI, ReadA, ReadB, EnRes, ResAdd, Flush,
        output DataA, DataB, BusyA, BusyB, AnyBusy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_sb : 2R/1W register file with registered reads, bypass   |
// |              and a per-register busy scoreboard                  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic    Clock,
    input  wire logic    Reset,
    regfile_sb_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [DEPTH-1:0] C_BUSY_MASK =
        (ZERO_REG != 0) ? {{(DEPTH-1){1'b1}}, 1'b0} : {DEPTH{1'b1}};

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busyNext;
    logic [WIDTH-1:0] r_dataA;
    logic [WIDTH-1:0] r_dataB;
    logic             r_busyA;
    logic             r_busyB;
    logic             w_wrValid;
    logic             w_resValid;

    // Register 0 neither accepts writes nor reservations when hard-wired.
    assign w_wrValid  = bus.EnWri && !((ZERO_REG != 0) && (bus.WriAdd == '0));
    assign w_resValid = bus.EnRes && !((ZERO_REG != 0) && (bus.ResAdd == '0));

    // Precedence: flush over reserve over write-release.
    always_comb begin
        w_busyNext = r_busy;
        if (w_wrValid) begin
            w_busyNext[bus.WriAdd] = 1'b0;
        end
        if (w_resValid) begin
            w_busyNext[bus.ResAdd] = 1'b1;
        end
        if (bus.Flush) begin
            w_busyNext = '0;
        end
        w_busyNext = w_busyNext & C_BUSY_MASK;
    end

    generate
        for (genvar p = 0; p < 2; p++) begin : g_readPort
            logic [ADDR_W-1:0] w_addr;
            logic [WIDTH-1:0]  w_data;
            logic              w_busy;

            assign w_addr = (p == 0) ? bus.ReadA : bus.ReadB;

            always_comb begin
                w_data = r_regs[w_addr];
                w_busy = r_busy[w_addr];
                if ((BYPASS != 0) && w_wrValid && (bus.WriAdd == w_addr)) begin
                    w_data = bus.DataI;
                    w_busy = 1'b0;
                end
                // A reservation landing this edge is visible immediately.
                if (w_resValid && (bus.ResAdd == w_addr)) begin
                    w_busy = 1'b1;
                end
                if (bus.Flush) begin
                    w_busy = 1'b0;
                end
                if ((ZERO_REG != 0) && (w_addr == '0)) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy  <= '0;
            r_dataA <= '0;
            r_dataB <= '0;
            r_busyA <= 1'b0;
            r_busyB <= 1'b0;
        end else begin
            if (w_wrValid) begin
                r_regs[bus.WriAdd] <= bus.DataI;
            end
            r_busy  <= w_busyNext;
            r_dataA <= g_readPort[0].w_data;
            r_dataB <= g_readPort[1].w_data;
            r_busyA <= g_readPort[0].w_busy;
            r_busyB <= g_readPort[1].w_busy;
        end
    end

    assign bus.DataA   = r_dataA;
    assign bus.DataB   = r_dataB;
    assign bus.BusyA   = r_busyA;
    assign bus.BusyB   = r_busyB;
    assign bus.AnyBusy = |(r_busy & C_BUSY_MASK);

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_regfile_sb : directed vector bench for regfile_sb             |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_regfile_sb;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    // A: default build; B: no bypass, no zero register; C: 64-bit, 8 entries
    regfile_sb_if #(.WIDTH(32), .ADDR_W(5)) ifA ();
    regfile_sb_if #(.WIDTH(32), .ADDR_W(5)) ifB ();
    regfile_sb_if #(.WIDTH(64), .ADDR_W(3)) ifC ();

    regfile_sb #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1))
        dutA (.Clock(Clock), .Reset(Reset), .bus(ifA.slave));
    regfile_sb #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0))
        dutB (.Clock(Clock), .Reset(Reset), .bus(ifB.slave));
    regfile_sb #(.WIDTH(64), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1))
        dutC (.Clock(Clock), .Reset(Reset), .bus(ifC.slave));

    assign ifB.EnWri  = ifA.EnWri;
    assign ifB.WriAdd = ifA.WriAdd;
    assign ifB.DataI  = ifA.DataI;
    assign ifB.ReadA  = ifA.ReadA;
    assign ifB.ReadB  = ifA.ReadB;
    assign ifB.EnRes  = ifA.EnRes;
    assign ifB.ResAdd = ifA.ResAdd;
    assign ifB.Flush  = ifA.Flush;

    assign ifC.EnWri  = ifA.EnWri;
    assign ifC.WriAdd = ifA.WriAdd[2:0];
    assign ifC.DataI  = {ifA.DataI, ifA.DataI};
    assign ifC.ReadA  = ifA.ReadA[2:0];
    assign ifC.ReadB  = ifA.ReadB[2:0];
    assign ifC.EnRes  = ifA.EnRes;
    assign ifC.ResAdd = ifA.ResAdd[2:0];
    assign ifC.Flush  = ifA.Flush;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        ifA.EnWri  = 1'b0;
        ifA.WriAdd = '0;
        ifA.DataI  = '0;
        ifA.EnRes  = 1'b0;
        ifA.ResAdd = '0;
        ifA.Flush  = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [4:0]  wa;
        logic [31:0] d;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        r;
        logic [4:0]  rsa;
        logic        f;
        logic [31:0] eDA;
        logic        eBA;
        logic [31:0] eDB;
        logic        eBB;
        logic        eAny;
        logic [31:0] eDAb;
        logic        eBAb;
        logic [31:0] eDAc;
        logic        eAnyC;
    } vec_t;

    vec_t vecs [18];

    initial begin
        // w wa d  ra rb r rsa f | A: DA BA DB BB Any | B: DA BA | C: DA Any
        vecs[0]  = '{1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                     32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0,
                     32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0, 32'h12345678, 1'b0, 32'h12345678, 1'b0};
        vecs[2]  = '{1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd7, 1'b0, 5'd0, 1'b0,
                     32'hCAFEF00D, 1'b0, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0};
        vecs[3]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0,
                     32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd3, 1'b1, 5'd9, 1'b0,
                     32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1};
        vecs[5]  = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0,
                     32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1};
        vecs[6]  = '{1'b1, 5'd9, 32'h55, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0,
                     32'h55, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h55, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0,
                     32'h55, 1'b0, 32'h55, 1'b0, 1'b0, 32'h55, 1'b0, 32'h55, 1'b0};
        vecs[8]  = '{1'b1, 5'd9, 32'hA5A5, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0,
                     32'hA5A5, 1'b1, 32'hA5A5, 1'b1, 1'b1, 32'h55, 1'b1, 32'hA5A5, 1'b1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd7, 1'b0, 5'd0, 1'b0,
                     32'hA5A5, 1'b1, 32'h12345678, 1'b0, 1'b1, 32'hA5A5, 1'b1, 32'hA5A5, 1'b1};
        vecs[10] = '{1'b0, 5'd0, 32'h0, 5'd2, 5'd9, 1'b1, 5'd2, 1'b0,
                     32'h0, 1'b1, 32'hA5A5, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1};
        vecs[11] = '{1'b0, 5'd0, 32'h0, 5'd4, 5'd2, 1'b1, 5'd4, 1'b0,
                     32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1};
        vecs[12] = '{1'b0, 5'd0, 32'h0, 5'd31, 5'd4, 1'b1, 5'd31, 1'b0,
                     32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h12345678, 1'b1};
        vecs[13] = '{1'b1, 5'd4, 32'h44, 5'd6, 5'd31, 1'b1, 5'd6, 1'b1,
                     32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[14] = '{1'b0, 5'd0, 32'h0, 5'd4, 5'd6, 1'b0, 5'd0, 1'b0,
                     32'h44, 1'b0, 32'h0, 1'b0, 1'b0, 32'h44, 1'b0, 32'h44, 1'b0};
        vecs[15] = '{1'b0, 5'd0, 32'h0, 5'd2, 5'd9, 1'b0, 5'd0, 1'b0,
                     32'h0, 1'b0, 32'hA5A5, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[16] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0,
                     32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0};
        vecs[17] = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0,
                     32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0};

        idle();
        ifA.ReadA = '0;
        ifA.ReadB = '0;
        step();
        step();
        check("reset_DataA", 64'(ifA.DataA), 64'h0);
        check("reset_BusyA", 64'(ifA.BusyA), 64'h0);
        check("reset_AnyBusy", 64'(ifA.AnyBusy), 64'h0);

        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ifA.ReadA = 5'(i);
            ifA.ReadB = 5'(31 - i);
            step();
            check($sformatf("init_DataA[%0d]", i), 64'(ifA.DataA), 64'h0);
            check($sformatf("init_BusyA[%0d]", i), 64'(ifA.BusyA), 64'h0);
            check($sformatf("init_DataB[%0d]", 31 - i), 64'(ifA.DataB), 64'h0);
            check($sformatf("init_BusyB[%0d]", 31 - i), 64'(ifA.BusyB), 64'h0);
        end

        // Asynchronous reset clears outputs mid-cycle and discards the pending write
        ifA.EnWri  = 1'b1;
        ifA.WriAdd = 5'd5;
        ifA.DataI  = 32'h11;
        ifA.ReadA  = 5'd5;
        step();
        ifA.EnWri = 1'b0;
        step();
        check("pre_reset_DataA", 64'(ifA.DataA), 64'h11);
        ifA.EnWri = 1'b1;
        ifA.DataI = 32'hDEADBEEF;
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("async_reset_DataA", 64'(ifA.DataA), 64'h0);
        check("async_reset_DataA_B", 64'(ifB.DataA), 64'h0);
        step();
        @(negedge Clock);
        Reset = 1'b1;
        idle();
        step();
        check("reset_midwrite_DataA", 64'(ifA.DataA), 64'h0);
        check("reset_midwrite_DataA_B", 64'(ifB.DataA), 64'h0);

        for (int v = 0; v < 18; v++) begin
            ifA.EnWri  = vecs[v].w;
            ifA.WriAdd = vecs[v].wa;
            ifA.DataI  = vecs[v].d;
            ifA.ReadA  = vecs[v].ra;
            ifA.ReadB  = vecs[v].rb;
            ifA.EnRes  = vecs[v].r;
            ifA.ResAdd = vecs[v].rsa;
            ifA.Flush  = vecs[v].f;
            step();
            check($sformatf("v%0d_DataA", v), 64'(ifA.DataA), 64'(vecs[v].eDA));
            check($sformatf("v%0d_BusyA", v), 64'(ifA.BusyA), 64'(vecs[v].eBA));
            check($sformatf("v%0d_DataB", v), 64'(ifA.DataB), 64'(vecs[v].eDB));
            check($sformatf("v%0d_BusyB", v), 64'(ifA.BusyB), 64'(vecs[v].eBB));
            check($sformatf("v%0d_AnyBusy", v), 64'(ifA.AnyBusy), 64'(vecs[v].eAny));
            check($sformatf("v%0d_nobyp_DataA", v), 64'(ifB.DataA), 64'(vecs[v].eDAb));
            check($sformatf("v%0d_nobyp_BusyA", v), 64'(ifB.BusyA), 64'(vecs[v].eBAb));
            check($sformatf("v%0d_w64_DataA", v), ifC.DataA, {vecs[v].eDAc, vecs[v].eDAc});
            check($sformatf("v%0d_w64_AnyBusy", v), 64'(ifC.AnyBusy), 64'(vecs[v].eAnyC));
        end

        // Reserve-then-read costs one cycle: the flag holds on the following read too
        idle();
        ifA.EnRes  = 1'b1;
        ifA.ResAdd = 5'd12;
        ifA.ReadA  = 5'd1;
        step();
        idle();
        ifA.ReadA = 5'd12;
        ifA.ReadB = 5'd12;
        step();
        check("late_BusyA", 64'(ifA.BusyA), 64'h1);
        check("late_BusyB", 64'(ifA.BusyB), 64'h1);
        check("late_AnyBusy", 64'(ifA.AnyBusy), 64'h1);
        ifA.Flush = 1'b1;
        step();
        idle();
        check("flush_AnyBusy", 64'(ifA.AnyBusy), 64'h0);
        check("flush_BusyA", 64'(ifA.BusyA), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the team's 32x32 two-read/one-write register file.
- Adds a configurable data width and depth, an optional hard-wired zero register, and registered read ports with write-to-read bypass.
- Adds a per-register busy scoreboard so the pipeline control logic can detect pending writes.
- Sits between the decode stage (read and reserve requests) and the writeback stage (write and release).

Parameters:
WIDTH, 32, data bits per register
ADDR_W, 5, address bits; DEPTH = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never busy
BYPASS, 1, 1 = a same-cycle write to the addressed register is forwarded to the read output

Ports:
Clock  in  1  single clock; all state updates on the rising edge
Reset  in  1  asynchronous, active-low reset
EnWri  in  1  write enable
WriAdd  in  ADDR_W  write address
DataI  in  WIDTH  write data
ReadA  in  ADDR_W  read address, port A
ReadB  in  ADDR_W  read address, port B
DataA  out  WIDTH  registered read data, port A
DataB  out  WIDTH  registered read data, port B
BusyA  out  1  registered busy flag of ReadA, aligned with DataA
BusyB  out  1  registered busy flag of ReadB, aligned with DataB
EnRes  in  1  reserve request: marks ResAdd as having a pending write
ResAdd  in  ADDR_W  reserve address
Flush  in  1  synchronous clear of all busy bits
AnyBusy  out  1  combinational OR of all busy bits

Behaviour:
- Reset (Reset=0, asynchronous): all DEPTH registers, all busy bits, DataA, DataB, BusyA and BusyB go to 0 immediately. Reset mid-write discards the write. State is held while Reset=0.
- Write: EnWri=1 at a rising edge stores DataI in reg[WriAdd] and clears busy[WriAdd].
  - With ZERO_REG=1 and WriAdd=0, the write is dropped.
- Read latency is 1 cycle. At each edge, DataA <= reg[ReadA] and BusyA <= busy[ReadA] (port B identical).
  - BYPASS=1 and EnWri=1 and WriAdd==ReadA: DataA <= DataI and BusyA <= 0, unless the reserve rule below applies.
  - BYPASS=0: DataA <= old reg[ReadA] value; the new value appears one cycle later.
  - With ZERO_REG=1 and ReadA=0: DataA <= 0 and BusyA <= 0, always.
- Reserve: EnRes=1 sets busy[ResAdd] at the edge. Ignored when ZERO_REG=1 and ResAdd=0.
- Simultaneous write and reserve, same address:
  - Data is written.
  - The busy bit ends set (reserve wins; a new producer is issued).
  - Bypassed BusyA/BusyB report 1 when the read address equals both WriAdd and ResAdd.
- Reserving an address that is already busy keeps it busy; there is no counting, so a single producer per register is assumed.
- Busy flags from a reserve are visible on BusyA/BusyB at the edge after the reserve (reserve-then-read costs one cycle). A reserve and a read of the same address in the same cycle give BusyA = 1.
- Flush=1: all busy bits clear at the edge. Flush has priority over EnRes in the same cycle. A write in the same cycle still lands.
  - BusyA/BusyB sampled in the flush cycle report 0.
- AnyBusy is combinational from the busy bits (excluding register 0 when ZERO_REG=1).
- Both read ports are fully independent. ReadA==ReadB is legal and both ports return identical values.
- Out-of-range addresses cannot occur because DEPTH = 2**ADDR_W.

Test Plan:
- Reset → outputs and registers clear: release Reset, read all 32 addresses → every DataA/DataB = 0 and every BusyA/BusyB = 0. Assert Reset mid-write of 0xDEADBEEF to reg 5 → a later read of reg 5 returns 0.
- Basic write/read: write 0x12345678 to reg 7 at cycle N; read reg 7 on A and reg 7 on B at cycle N+1 → both ports show 0x12345678 at N+2.
- Bypass: write 0xCAFEF00D to reg 3 while ReadA=3 → with BYPASS=1, DataA=0xCAFEF00D after that edge. Rerun with BYPASS=0 → old value 0, and the new value only after the next edge.
- Zero register: write 0xFFFFFFFF to reg 0 and EnRes on reg 0 → DataA=0, BusyA=0, AnyBusy=0. With ZERO_REG=0, reg 0 reads back 0xFFFFFFFF.
- Scoreboard:
  - EnRes reg 9 → BusyA=1 when ReadA=9 next cycle, and AnyBusy=1.
  - Write reg 9 with 0x55 → BusyA=0 and DataA=0x55.
  - Simultaneous write and reserve on reg 9 → BusyA=1 and DataA equals the new data.
- Flush: reserve regs 2, 4 and 31, then Flush together with EnRes on reg 6 → all busy bits 0 (including reg 6) and AnyBusy=0. A WIDTH=64, ADDR_W=3 build passes the same sequence with addresses taken mod 8.
